// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, ALU function codes,
// FSM states, instruction classes and the privileged/CSR instruction encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] RType  = 7'b0110011;
    localparam logic [6:0] IType  = 7'b0010011;
    localparam logic [6:0] LType  = 7'b0000011;
    localparam logic [6:0] IJalr  = 7'b1100111;
    localparam logic [6:0] SType  = 7'b0100011;
    localparam logic [6:0] SBType = 7'b1100011;
    localparam logic [6:0] UJType = 7'b1101111;
    localparam logic [6:0] EType  = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_TRAP  = 2'd3
    } ctrl_state_t;

    typedef enum logic [3:0] {
        CL_NONE,
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_ECALL,
        CL_MRET,
        CL_CSRR
    } instr_class_t;

    localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSN_MRET  = 32'h3020_0073;
    localparam logic [11:0] CSR_SEPC   = 12'h141;
    localparam logic [2:0]  F3_CSRRS   = 3'b010;

endpackage

// File: rtl/riscv_decode.sv
// Combinational decode of the latched instruction into immediate, ALU function,
// operand-B select and an instruction class for the sequencing FSM.
module riscv_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int WIDTH_ALUF = 4
) (
    input  logic [31:0]           instr,
    output logic [NBITS-1:0]      imm,
    output logic [WIDTH_ALUF-1:0] alu_ctrl,
    output logic                  alu_src,
    output instr_class_t          cls
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_ext;
    logic [3:0]  alu_code;

    always_comb begin
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        imm_ext  = '0;
        alu_code = ALU_ADD;
        alu_src  = 1'b0;
        cls      = CL_NONE;
        unique case (opcode)
            RType: begin
                cls      = CL_ALU;
                alu_code = {instr[30], funct3};
            end
            IType: begin
                cls      = CL_ALU;
                alu_src  = 1'b1;
                imm_ext  = {{20{instr[31]}}, instr[31:20]};
                // funct7[5] only selects SRAI; for other I-types those bits are immediate
                alu_code = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
            end
            LType: begin
                cls     = CL_LOAD;
                alu_src = 1'b1;
                imm_ext = {{20{instr[31]}}, instr[31:20]};
            end
            IJalr: begin
                cls     = CL_JALR;
                alu_src = 1'b1;
                imm_ext = {{20{instr[31]}}, instr[31:20]};
            end
            SType: begin
                cls     = CL_STORE;
                alu_src = 1'b1;
                imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            SBType: begin
                cls      = CL_BRANCH;
                alu_code = ALU_SUB;
                imm_ext  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            UJType: begin
                cls     = CL_JAL;
                imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            EType: begin
                if (instr == INSN_ECALL)
                    cls = CL_ECALL;
                else if (instr == INSN_MRET)
                    cls = CL_MRET;
                else if (funct3 == F3_CSRRS && instr[31:20] == CSR_SEPC && instr[19:15] == 5'd0)
                    cls = CL_CSRR;
            end
            default: ;
        endcase
        imm      = NBITS'(imm_ext);
        alu_ctrl = WIDTH_ALUF'(alu_code);
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control unit: fetch/execute/memory sequencing, branch resolution,
// and a single-level interrupt/ECALL trap with sepc save and MRET return.
//
// state   | meaning
// S_FETCH | request instruction, latch it on imem_ready
// S_EXEC  | decode, strobe datapath, update pc (non-memory ops)
// S_MEM   | hold data strobe until !busy, then update pc
// S_TRAP  | sepc <= pc (already the return pc), pc <= TRAP_VECTOR
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int          NBITS        = 8,
    parameter int          NREGS        = 32,
    parameter int          WIDTH_ALUF   = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter logic [31:0] TRAP_VECTOR  = 32'h80
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [NBITS-1:0]         imem_addr,
    output logic                     imem_req,
    input  logic                     imem_ready,
    input  logic [31:0]              imem_rdata,
    output logic [$clog2(NREGS)-1:0] RS1,
    output logic [$clog2(NREGS)-1:0] RS2,
    output logic [$clog2(NREGS)-1:0] RD,
    output logic [NBITS-1:0]         IMM,
    output logic                     ALUSrc,
    output logic [WIDTH_ALUF-1:0]    ALUControl,
    output logic                     RegWrite,
    output logic                     MemtoReg,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     link,
    output logic [NBITS-1:0]         pclink,
    input  logic                     busy,
    input  logic                     Zero,
    input  logic                     Neg,
    input  logic                     Carry,
    input  logic [NBITS-1:0]         PCReg,
    input  logic                     interrupt,
    output logic [NBITS-1:0]         pc
);

    localparam int RW = $clog2(NREGS);

    ctrl_state_t  state, state_next;
    instr_class_t cls;
    logic [31:0]      instr;
    logic [NBITS-1:0] pc_next, pc_plus4, sepc;
    logic             in_isr, pend, irq_ok, take_irq, clr_isr, br_taken;

    riscv_decode #(.NBITS(NBITS), .WIDTH_ALUF(WIDTH_ALUF)) u_decode (
        .instr    (instr),
        .imm      (IMM),
        .alu_ctrl (ALUControl),
        .alu_src  (ALUSrc),
        .cls      (cls)
    );

    assign RS1       = instr[15 +: RW];
    assign RS2       = instr[20 +: RW];
    assign RD        = instr[7 +: RW];
    assign imem_addr = pc;
    assign pc_plus4  = pc + NBITS'(4);
    assign pclink    = (cls == CL_CSRR) ? sepc : pc_plus4;
    // the live request line counts too, so a pulse during EXEC is not lost
    assign irq_ok    = (pend | interrupt) & ~in_isr;

    always_comb begin
        unique case (instr[14:12])
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = ~Zero;
            3'b100:  br_taken = Neg;
            3'b101:  br_taken = ~Neg;
            3'b110:  br_taken = ~Carry;
            3'b111:  br_taken = Carry;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        imem_req   = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        link       = 1'b0;
        take_irq   = 1'b0;
        clr_isr    = 1'b0;
        unique case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready)
                    state_next = S_EXEC;
            end
            S_EXEC: begin
                pc_next = pc_plus4;
                unique case (cls)
                    CL_ALU:    RegWrite = 1'b1;
                    CL_BRANCH: if (br_taken) pc_next = pc + IMM;
                    CL_JAL: begin
                        RegWrite = 1'b1;
                        link     = 1'b1;
                        pc_next  = pc + IMM;
                    end
                    CL_JALR: begin
                        RegWrite = 1'b1;
                        link     = 1'b1;
                        pc_next  = PCReg & ~NBITS'(1);
                    end
                    CL_CSRR: begin
                        RegWrite = 1'b1;
                        link     = 1'b1;
                    end
                    CL_MRET: begin
                        pc_next = sepc;
                        clr_isr = 1'b1;
                    end
                    default: ;
                endcase
                if (cls == CL_LOAD || cls == CL_STORE) begin
                    pc_next    = pc;
                    state_next = S_MEM;
                end else if (cls == CL_ECALL) begin
                    state_next = S_TRAP;
                end else if (irq_ok) begin
                    take_irq   = 1'b1;
                    state_next = S_TRAP;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                MemRead  = (cls == CL_LOAD);
                MemWrite = (cls == CL_STORE);
                MemtoReg = (cls == CL_LOAD);
                if (!busy) begin
                    RegWrite   = (cls == CL_LOAD);
                    pc_next    = pc_plus4;
                    take_irq   = irq_ok;
                    state_next = irq_ok ? S_TRAP : S_FETCH;
                end
            end
            S_TRAP: begin
                pc_next    = NBITS'(TRAP_VECTOR);
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            link     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= NBITS'(RESET_VECTOR);
            sepc   <= '0;
            in_isr <= 1'b0;
            pend   <= 1'b0;
            instr  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == S_FETCH && imem_ready)
                instr <= imem_rdata;
            if (state == S_TRAP) begin
                sepc   <= pc;
                in_isr <= 1'b1;
            end else if (clr_isr) begin
                in_isr <= 1'b0;
            end
            pend <= take_irq ? 1'b0 : (pend | interrupt);
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: a small program image walks through ALU,
// branch, load stall, interrupt/ECALL traps, jumps, pc wrap and reset inside MEM.
module tb_riscv_mc_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [4:0]  RS1, RS2, RD;
    logic [7:0]  IMM;
    logic        ALUSrc;
    logic [3:0]  ALUControl;
    logic        RegWrite, MemtoReg, MemRead, MemWrite, link;
    logic [7:0]  pclink;
    logic        busy, Zero, Neg, Carry;
    logic [7:0]  PCReg;
    logic        interrupt;
    logic [7:0]  pc;

    logic [31:0] prog [64];
    int checks   = 0;
    int failures = 0;
    int mr_cycles, rw_cycles;

    always #5 clock = ~clock;

    assign imem_rdata = prog[imem_addr[7:2]];

    riscv_mc_controller dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .RS1        (RS1),
        .RS2        (RS2),
        .RD         (RD),
        .IMM        (IMM),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .link       (link),
        .pclink     (pclink),
        .busy       (busy),
        .Zero       (Zero),
        .Neg        (Neg),
        .Carry      (Carry),
        .PCReg      (PCReg),
        .interrupt  (interrupt),
        .pc         (pc)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0]  = 32'h0050_0093;  // 0x00 addi x1,x0,5
        prog[1]  = 32'h0020_8463;  // 0x04 beq  x1,x2,+8
        prog[2]  = 32'h0030_A023;  // 0x08 sw   x3,0(x1)
        prog[3]  = 32'h0020_8463;  // 0x0C beq  x1,x2,+8
        prog[4]  = 32'h4030_D113;  // 0x10 srai x2,x1,3
        prog[5]  = 32'h0020_E463;  // 0x14 bltu x1,x2,+8
        prog[7]  = 32'h0040_A183;  // 0x1C lw   x3,4(x1)
        prog[8]  = 32'h0000_0073;  // 0x20 ecall
        prog[9]  = 32'h4020_81B3;  // 0x24 sub  x3,x1,x2
        prog[10] = 32'h0001_00E7;  // 0x28 jalr x1,0(x2)
        prog[12] = 32'h0CC0_00EF;  // 0x30 jal  x1,+0xCC
        prog[32] = 32'h1410_22F3;  // 0x80 csrr x5,sepc
        prog[33] = 32'h3020_0073;  // 0x84 mret
        prog[63] = 32'h0030_A023;  // 0xFC sw   x3,0(x1)

        reset = 1'b1; imem_ready = 1'b1; busy = 1'b0; interrupt = 1'b0;
        Zero = 1'b0; Neg = 1'b0; Carry = 1'b1; PCReg = 8'h00;
        cyc(); cyc();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_memrd",    MemRead,  0);
        chk("rst_memwr",    MemWrite, 0);
        chk("rst_link",     link,     0);
        chk("rst_pc",       pc,       8'h00);
        reset = 1'b0; #1;
        chk("post_rst_req", imem_req, 1);
        chk("fetch_addr",   imem_addr, 8'h00);

        // addi x1,x0,5: two cycles with zero-wait fetch
        cyc();
        chk("addi_rw",   RegWrite,   1);
        chk("addi_rd",   RD,         1);
        chk("addi_imm",  IMM,        8'h05);
        chk("addi_aluc", ALUControl, 4'h0);
        chk("addi_src",  ALUSrc,     1);
        chk("addi_req",  imem_req,   0);
        cyc();
        chk("addi_pc",   pc,         8'h04);
        chk("addi_rw_once", RegWrite, 0);

        // beq taken
        cyc();
        Zero = 1'b1; #1;
        chk("beq_aluc", ALUControl, 4'h8);
        chk("beq_imm",  IMM,        8'h08);
        chk("beq_rs1",  RS1,        1);
        chk("beq_rs2",  RS2,        2);
        chk("beq_rw",   RegWrite,   0);
        cyc();
        chk("beq_taken_pc", pc, 8'h0C);
        Zero = 1'b0;
        // beq not taken
        cyc(); cyc();
        chk("beq_nt_pc", pc, 8'h10);

        // srai with a one-cycle interrupt pulse during EXEC
        cyc();
        interrupt = 1'b1; #1;
        chk("srai_aluc", ALUControl, 4'hD);
        chk("srai_imm",  IMM,        8'h03);
        chk("srai_rw",   RegWrite,   1);
        cyc();
        interrupt = 1'b0; #1;
        chk("trap_rw",  RegWrite, 0);
        chk("trap_req", imem_req, 0);
        cyc();
        chk("irq_vec_pc", pc, 8'h80);
        cyc();
        chk("csrr_link",   link,     1);
        chk("csrr_sepc",   pclink,   8'h14);
        chk("csrr_rd",     RD,       5);
        chk("csrr_rw",     RegWrite, 1);
        cyc(); cyc();
        chk("mret_rw", RegWrite, 0);
        cyc();
        chk("mret_pc", pc, 8'h14);

        // bltu with Carry=0 (borrow) is taken
        Carry = 1'b0;
        cyc(); cyc();
        chk("bltu_pc", pc, 8'h1C);
        Carry = 1'b1;

        // lw with busy high for three MEM cycles; busy in EXEC is ignored
        mr_cycles = 0; rw_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            busy = (i >= 1 && i <= 4); #1;
            mr_cycles += int'(MemRead);
            rw_cycles += int'(RegWrite);
            if (i == 5) chk("lw_memtoreg", MemtoReg, 1);
            cyc();
        end
        busy = 1'b0;
        chk("lw_memread_cycles", mr_cycles, 4);
        chk("lw_regwrite_cycles", rw_cycles, 1);
        chk("lw_pc", pc, 8'h20);
        chk("lw_done_req", imem_req, 1);

        // ecall with interrupt held high: ecall first, irq after return
        interrupt = 1'b1;
        cyc();
        chk("ecall_rw", RegWrite, 0);
        cyc();
        chk("ecall_ret_pc", pc, 8'h24);
        cyc();
        chk("ecall_vec_pc", pc, 8'h80);
        cyc();
        chk("ecall_sepc", pclink, 8'h24);
        cyc();
        chk("no_nest_pc", pc, 8'h84);
        cyc(); cyc();
        chk("ecall_mret_pc", pc, 8'h24);
        cyc();
        chk("sub_aluc", ALUControl, 4'h8);
        chk("sub_src",  ALUSrc,     0);
        chk("sub_imm",  IMM,        8'h00);
        chk("sub_rw",   RegWrite,   1);
        cyc();
        interrupt = 1'b0; #1;
        chk("irq2_trap_pc", pc, 8'h28);
        cyc();
        chk("irq2_vec_pc", pc, 8'h80);
        cyc();
        chk("irq2_sepc", pclink, 8'h28);
        cyc(); cyc(); cyc();
        chk("irq2_mret_pc", pc, 8'h28);

        // fetch stall, then jalr clears bit 0 of the target
        imem_ready = 1'b0; PCReg = 8'h31;
        cyc();
        chk("stall_req", imem_req, 1);
        chk("stall_pc",  pc,       8'h28);
        chk("stall_rw",  RegWrite, 0);
        imem_ready = 1'b1;
        cyc();
        chk("jalr_link",   link,   1);
        chk("jalr_pclink", pclink, 8'h2C);
        cyc();
        chk("jalr_pc", pc, 8'h30);
        cyc();
        chk("jal_imm",    IMM,    8'hCC);
        chk("jal_pclink", pclink, 8'h34);
        cyc();
        chk("jal_pc", pc, 8'hFC);

        // store at 0xFC wraps pc to 0x00
        cyc();
        chk("sw_exec_memwr", MemWrite, 0);
        cyc();
        chk("sw_mem_memwr", MemWrite, 1);
        chk("sw_mem_rw",    RegWrite, 0);
        cyc();
        chk("wrap_pc", pc, 8'h00);

        // reset while a store is held in MEM by busy
        cyc(); cyc(); cyc(); cyc();
        chk("pre_sw_pc", pc, 8'h08);
        cyc();
        busy = 1'b1;
        cyc();
        chk("held_sw_memwr", MemWrite, 1);
        cyc();
        chk("held_sw_memwr2", MemWrite, 1);
        reset = 1'b1;
        cyc();
        chk("rst_mem_memwr", MemWrite, 0);
        chk("rst_mem_pc",    pc,       8'h00);
        reset = 1'b0; busy = 1'b0; #1;
        chk("rst_mem_req",   imem_req, 1);
        cyc();
        chk("rst_mem_memwr2", MemWrite, 0);
        chk("rst_mem_addi_rw", RegWrite, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

Multicycle control unit for the parametrised RISC-V core; successor to the single-cycle 8-bit controller. Sequences each instruction through fetch, execute and optional memory states. Stalls on instruction and data memory latency, resolves conditional branches from ALU flags, and takes one level of interrupt/ECALL trap with `sepc` save and MRET return. Sits between instruction memory, data memory/cache and the register-file/ALU datapath.

## Interface
- `NBITS`, 8: datapath and PC width (8..32).
- `NREGS`, 32: register count; register index width is `$clog2(NREGS)`.
- `WIDTH_ALUF`, 4: ALU function code width.
- `RESET_VECTOR`, 0: PC after reset.
- `TRAP_VECTOR`, 'h80: PC on trap entry, truncated to NBITS.

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `imem_addr`  out  NBITS  fetch address (= `pc`).
- `imem_req`  out  1  fetch request.
- `imem_ready`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `RS1`, `RS2`, `RD`  out  $clog2(NREGS)  register indices from the latched instruction.
- `IMM`  out  NBITS  signed immediate.
- `ALUSrc`  out  1  ALU operand B = IMM.
- `ALUControl`  out  WIDTH_ALUF  ALU function code.
- `RegWrite`  out  1  register write strobe, one cycle per instruction.
- `MemtoReg`  out  1  write-back from memory.
- `MemRead`, `MemWrite`  out  1  data memory strobes.
- `link`  out  1  write `pclink` to RD.
- `pclink`  out  NBITS  link value (pc+4, or `sepc` for CSRR).
- `busy`  in  1  data memory not ready.
- `Zero`, `Neg`, `Carry`  in  1  ALU flags from SUB. `Carry=1` means no borrow, i.e. rs1 >= rs2 unsigned.
- `PCReg`  in  NBITS  rs1 + IMM for JALR.
- `interrupt`  in  1  level-sensitive interrupt request.
- `pc`  out  NBITS  current PC.

## Operation
- **States:**
  - FETCH: hold `imem_req`=1 until `imem_ready`, then latch the instruction and go to EXEC.
  - EXEC: decode and assert strobes. Loads/stores go to MEM. A trap condition goes to TRAP. Otherwise go to FETCH.
  - MEM: hold MemRead/MemWrite while `busy`. On `!busy`: a load pulses RegWrite with MemtoReg=1, then go to FETCH.
  - TRAP: `sepc` ← return PC, `pc` ← TRAP_VECTOR, `in_isr` ← 1, then go to FETCH.
- **PC update** (modulo 2^NBITS), in EXEC or at the end of MEM:
  - Default: pc+4.
  - Taken branch or JAL: pc+IMM.
  - JALR: `PCReg` with bit 0 cleared.
  - MRET: `sepc`, and `in_isr` ← 0.
- **Branch conditions:**
  - BEQ: Zero. BNE: !Zero.
  - BLT: Neg. BGE: !Neg.
  - BLTU: !Carry. BGEU: Carry.
- **ALUControl:** R-type uses {funct7[5], funct3}. I-type uses {funct3==101 ? funct7[5] : 0, funct3}. Branches use SUB. Load/store/jumps use ADD.
- **IMM:** I/S/B/J formats, sign-extended from the instruction field, then truncated to NBITS. R-type gives IMM = 0.
- **Link:** JAL/JALR assert `link` with `pclink` = pc+4. `csrr rd, sepc` asserts `link` with `pclink` = `sepc`.
- **Pending interrupt:** `pend` sets on `interrupt`=1 and clears on interrupt trap entry. It is sampled only at the EXEC→FETCH or MEM→FETCH transition; if `pend && !in_isr`, go to TRAP instead.
  - Interrupt trap: `sepc` = next PC.
  - ECALL trap (taken regardless of `in_isr`): `sepc` = pc+4.
- **Simultaneous ECALL and interrupt:** ECALL traps first; `pend` is kept.
- **Unknown opcode:** no strobes, pc+4.

## Timing
- **Reset values:**
  - State FETCH, `pc`=RESET_VECTOR, `sepc`=0, `in_isr`=0, `pend`=0.
  - All strobes (`imem_req`, RegWrite, MemRead, MemWrite, link) are 0 during reset; `imem_req`=1 in the first cycle after.
- **Latency:**
  - ALU, branch or jump: 2 cycles with zero-wait fetch.
  - Load/store: 3 cycles + busy cycles.
  - Trap entry: +1 cycle.
- Strobes are combinational from state plus the latched instruction. RegWrite is exactly one cycle, never asserted in FETCH or TRAP.
- **Reset mid-instruction:** aborts the instruction; no strobe follows. A held store does not complete.
- `imem_rdata` is ignored unless `imem_ready`. `busy` is ignored outside MEM.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode constants (RType, IType, LType, IJalr, SType, SBType, UJType, EType);
  - ALU function codes (ADD..AND);
  - the state enum `ctrl_state_t`;
  - the MRET/CSR encodings.
- Sub-module `riscv_decode` (combinational): instruction to IMM, ALUControl, ALUSrc, instruction class. The FSM, PC, `sepc`, `pend` and `in_isr` stay in the top level.

## Test plan
- **Reset/ALU:** reset, then `addi x1,x0,5` with `imem_ready` tied 1 → `pc` 0→4 in 2 cycles; RegWrite pulse, RD=1, IMM=5, ALUControl=ADD.
- **Branch:** `beq` IMM=8 with Zero=1 → pc+8; with Zero=0 → pc+4. `bltu` with Carry=0 → taken.
- **Load stall:** `lw` with `busy` high 3 cycles → MemRead held 4 cycles; a single RegWrite pulse with MemtoReg=1; total 6 cycles.
- **Interrupt:** pulse `interrupt` 1 cycle during EXEC at pc=0x10 → TRAP, `pc`=0x80, `sepc`=0x14. MRET → `pc`=0x14, `in_isr`=0.
- **Nesting/ECALL:** `interrupt` held high inside ISR → no re-entry until MRET. ECALL at 0x20 with interrupt high → `sepc`=0x24, ECALL first, interrupt taken after return.
- **Wrap/reset:** NBITS=8, pc=0xFC → next pc 0x00. Assert reset while in MEM with busy high → MemWrite 0 next cycle, `pc`=RESET_VECTOR.
